// File: rtl/br_tag_alloc.sv
// Branch-tag allocator and speculation-mask controller: in-order multi-slot tag grant, free/squash on resolve.
// Optional BR_TAG_BYPASS_EN: a tag freed by a correct resolution is allocatable in the same cycle.
module br_tag_alloc #(
  parameter int NUM_TAGS = 8,
  parameter int DISP_W   = 2,
  localparam int CNT_W   = $clog2(NUM_TAGS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISP_W-1:0]                alloc_req_i,
  output logic [DISP_W-1:0]                alloc_gnt_o,
  output logic [DISP_W-1:0][NUM_TAGS-1:0]  alloc_bit_o,
  output logic [DISP_W-1:0][NUM_TAGS-1:0]  alloc_mask_o,
  input  logic                             res_valid_i,
  input  logic                             res_wrong_i,
  input  logic [NUM_TAGS-1:0]              res_bit_i,
  input  logic [NUM_TAGS-1:0]              res_dep_mask_i,
  output logic [NUM_TAGS-1:0]              clr_bit_o,
  output logic [NUM_TAGS-1:0]              squash_mask_o,
  output logic [NUM_TAGS-1:0]              cur_mask_o,
  output logic [CNT_W-1:0]                 free_cnt_o,
  output logic                             full_o,
  output logic                             err_o
);

  localparam logic [NUM_TAGS-1:0] ONE_TAG = NUM_TAGS'(1);

  logic [NUM_TAGS-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                err_reg, err_next;

  logic                res_ok, res_bad;
  logic [NUM_TAGS-1:0] eff_mask, pool;
  logic [NUM_TAGS-1:0] avail, pick, acc;
  logic                blocked;

  logic [DISP_W-1:0]               gnt_comb;
  logic [DISP_W-1:0][NUM_TAGS-1:0] bit_comb;
  logic [DISP_W-1:0][NUM_TAGS-1:0] amask_comb;

  assign res_ok   = res_valid_i & ~res_wrong_i;
  assign res_bad  = res_valid_i & res_wrong_i;
  assign eff_mask = res_ok ? (mask_reg & ~res_bit_i) : mask_reg;

`ifdef BR_TAG_BYPASS_EN
  assign pool = ~eff_mask;
`else
  assign pool = ~mask_reg;
`endif

  // In-order grant: a requesting slot that finds the pool empty blocks every younger slot.
  always_comb begin
    gnt_comb   = '0;
    bit_comb   = '0;
    amask_comb = '0;
    avail      = pool;
    pick       = '0;
    blocked    = 1'b0;
    acc        = eff_mask;
    for (int k = 0; k < DISP_W; k++) begin
      if (alloc_req_i[k] && !blocked && !res_bad) begin
        if (avail != '0) begin
          pick        = avail & (~avail + ONE_TAG);
          gnt_comb[k] = 1'b1;
          bit_comb[k] = pick;
          avail       = avail & ~pick;
        end else begin
          blocked = 1'b1;
        end
      end
      amask_comb[k] = acc;
      acc           = acc | bit_comb[k];
    end
  end

  always_comb begin
    mask_next = res_bad ? (mask_reg & res_dep_mask_i) : acc;
    cnt_next  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!mask_next[i]) cnt_next = cnt_next + CNT_W'(1);
    end
    err_next = err_reg |
               (res_valid_i & (!$onehot(res_bit_i) ||
                               ((res_bit_i & mask_reg) == '0) ||
                               ((res_dep_mask_i & res_bit_i) != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= '0;
      cnt_reg  <= CNT_W'(NUM_TAGS);
      err_reg  <= 1'b0;
    end else begin
      mask_reg <= mask_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

  for (genvar gi = 0; gi < DISP_W; gi++) begin : g_slot
    assign alloc_gnt_o[gi]  = gnt_comb[gi];
    assign alloc_bit_o[gi]  = bit_comb[gi];
    assign alloc_mask_o[gi] = amask_comb[gi];
  end

  assign clr_bit_o     = res_valid_i ? res_bit_i : '0;
  assign squash_mask_o = res_bad ? (mask_reg & ~res_dep_mask_i) : '0;
  assign cur_mask_o    = mask_reg;
  assign free_cnt_o    = cnt_reg;
  assign full_o        = &mask_reg;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_br_tag_alloc.sv
// Self-checking bench for br_tag_alloc: directed scenarios then random traffic against a queue-based model.
module tb_br_tag_alloc;
  localparam int NT = 8;
  localparam int DW = 2;
  localparam int CW = $clog2(NT + 1);
`ifdef BR_TAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0]         alloc_req_i;
  logic [DW-1:0]         alloc_gnt_o;
  logic [DW-1:0][NT-1:0] alloc_bit_o;
  logic [DW-1:0][NT-1:0] alloc_mask_o;
  logic                  res_valid_i, res_wrong_i;
  logic [NT-1:0]         res_bit_i, res_dep_mask_i;
  logic [NT-1:0]         clr_bit_o, squash_mask_o, cur_mask_o;
  logic [CW-1:0]         free_cnt_o;
  logic                  full_o, err_o;

  br_tag_alloc #(.NUM_TAGS(NT), .DISP_W(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_bit_o(alloc_bit_o), .alloc_mask_o(alloc_mask_o),
    .res_valid_i(res_valid_i), .res_wrong_i(res_wrong_i),
    .res_bit_i(res_bit_i), .res_dep_mask_i(res_dep_mask_i),
    .clr_bit_o(clr_bit_o), .squash_mask_o(squash_mask_o),
    .cur_mask_o(cur_mask_o), .free_cnt_o(free_cnt_o),
    .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit in_flight[NT];  // model: which tags are outstanding
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0] model_mask();
    logic [NT-1:0] m = '0;
    for (int i = 0; i < NT; i++) if (in_flight[i]) m[i] = 1'b1;
    return m;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic [DW-1:0] req, input logic rv, input logic rw,
                       input logic [NT-1:0] rb, input logic [NT-1:0] rd);
    int            fq[$];
    int            nfree;
    int            idx;
    bit            stop, ok_res, bad_res;
    bit            nxt[NT];
    logic [DW-1:0] eg;
    logic [NT-1:0] eb[DW];
    logic [NT-1:0] em[DW];
    logic [NT-1:0] cur, eff, acc;
    rst = r; alloc_req_i = req; res_valid_i = rv; res_wrong_i = rw;
    res_bit_i = rb; res_dep_mask_i = rd;
    #1;
    cur   = model_mask();
    nfree = 0;
    for (int i = 0; i < NT; i++) if (!in_flight[i]) nfree++;
    chk("cur_mask", 64'(cur_mask_o), 64'(cur));
    chk("free_cnt", 64'(free_cnt_o), 64'(nfree));
    chk("full", 64'(full_o), 64'(nfree == 0));
    chk("err", 64'(err_o), 64'(m_err));

    ok_res  = rv && !rw;
    bad_res = rv && rw;
    eff = cur;
    if (ok_res) eff = cur & ~rb;
    for (int i = 0; i < NT; i++)
      if (!in_flight[i] || (BYP && ok_res && rb[i])) fq.push_back(i);
    eg = '0; stop = 0; acc = eff;
    for (int k = 0; k < DW; k++) begin
      eb[k] = '0;
      if (req[k] && !stop && !bad_res) begin
        if (fq.size() > 0) begin
          idx   = fq.pop_front();
          eg[k] = 1'b1;
          eb[k] = NT'(1) << idx;
        end else stop = 1;
      end
      em[k] = acc;
      acc   = acc | eb[k];
    end

    if (!r) begin
      chk("gnt", 64'(alloc_gnt_o), 64'(eg));
      for (int k = 0; k < DW; k++) begin
        chk($sformatf("bit%0d", k), 64'(alloc_bit_o[k]), 64'(eb[k]));
        chk($sformatf("amask%0d", k), 64'(alloc_mask_o[k]), 64'(em[k]));
      end
      chk("clr_bit", 64'(clr_bit_o), rv ? 64'(rb) : 64'd0);
      chk("squash", 64'(squash_mask_o), bad_res ? 64'(cur & ~rd) : 64'd0);
    end

    for (int i = 0; i < NT; i++) begin
      if (bad_res) nxt[i] = in_flight[i] && rd[i];
      else         nxt[i] = acc[i];
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < NT; i++) in_flight[i] = 0;
      m_err = 0;
    end else begin
      if (rv && ($countones(rb) != 1 || (rb & cur) == '0 || (rd & rb) != '0)) m_err = 1;
      for (int i = 0; i < NT; i++) in_flight[i] = nxt[i];
    end
  endtask

  task automatic idle(input logic r);
    cycle(r, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int            live[$];
    logic [NT-1:0] rb, rd;
    logic          rv, rw;
    rst = 1'b1; alloc_req_i = '0; res_valid_i = 1'b0; res_wrong_i = 1'b0;
    res_bit_i = '0; res_dep_mask_i = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NT; i++) in_flight[i] = 0;
    m_err = 0;

    // reset state and fill with two-wide bundles
    idle(1'b0);
    repeat (4) cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    // full, one request, correct resolve of tag 2
    cycle(1'b0, 2'b01, 1'b1, 1'b0, 8'h04, 8'h03);
    cycle(1'b0, 2'b01, 1'b0, 1'b0, '0, '0);
    idle(1'b0);

    // mask 0x0F, wrong resolve of tag 1 with dep 0x01
    idle(1'b1);
    repeat (2) cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b11, 1'b1, 1'b1, 8'h02, 8'h01);
    idle(1'b0);

    // mask 0xFE: slot 1 denied, then lone slot-1 request
    idle(1'b1);
    repeat (4) cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 8'h00);
    cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 8'h00);
    cycle(1'b0, 2'b10, 1'b0, 1'b0, '0, '0);
    idle(1'b0);

    // resolve of a tag not in flight sets sticky err
    idle(1'b1);
    repeat (2) cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h20, 8'h00);
    cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 8'h00);
    idle(1'b0);

    // build mask 0x3C, then rst mid-stream
    idle(1'b1);
    repeat (3) cycle(1'b0, 2'b11, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 8'h00);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 8'h02, 8'h00);
    cycle(1'b1, 2'b11, 1'b1, 1'b1, 8'h04, 8'h00);
    idle(1'b0);

    // random traffic, mostly legal resolutions of in-flight tags
    for (int n = 0; n < 400; n++) begin
      live.delete();
      for (int i = 0; i < NT; i++) if (in_flight[i]) live.push_back(i);
      rv = 1'b0; rw = 1'b0; rb = '0; rd = '0;
      if ($urandom_range(0, 19) == 0) begin
        rv = 1'b1; rw = 1'($urandom); rb = NT'($urandom); rd = NT'($urandom);
      end else if (live.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv = 1'b1;
        rw = ($urandom_range(0, 3) == 0);
        rb = NT'(1) << live[$urandom_range(0, live.size() - 1)];
        rd = model_mask() & ~rb & NT'($urandom);
      end
      cycle($urandom_range(0, 99) == 0, DW'($urandom), rv, rw, rb, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/br_tag_alloc.md
# br_tag_alloc

Parametrised, multi-dispatch branch-tag allocator and speculation-mask controller for the out-of-order core. It tracks which of NUM_TAGS branch tags are in flight and hands up to DISP_W tags per cycle to dispatch, with the dependency mask each dispatched instruction must carry. It frees tags on correct resolution and squashes the mispredicted branch and all younger tags on a wrong resolution. It sits between dispatch, the ROB/RS (mask consumers) and the branch stack (checkpoint index = tag bit).

## Interface
- NUM_TAGS, 8: number of branch tags and mask width; legal range 2..16.
- DISP_W, 2: branch allocation ports per cycle; legal range 1..4.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req_i  in  DISP_W  per-slot branch dispatch request; slot 0 is oldest
- alloc_gnt_o  out  DISP_W  per-slot grant; combinational, same cycle
- alloc_bit_o  out  DISP_W×NUM_TAGS  one-hot tag given to each granted slot; zero if not granted
- alloc_mask_o  out  DISP_W×NUM_TAGS  dependency mask per slot; excludes the slot's own bit
- res_valid_i  in  1  a branch resolves this cycle
- res_wrong_i  in  1  1 = mispredicted, 0 = correct
- res_bit_i  in  NUM_TAGS  one-hot tag of the resolving branch
- res_dep_mask_i  in  NUM_TAGS  dependency mask stored with the resolving branch
- clr_bit_o  out  NUM_TAGS  one-hot broadcast of the resolved tag to RS/ROB; combinational
- squash_mask_o  out  NUM_TAGS  tags killed by a wrong resolution this cycle; combinational
- cur_mask_o  out  NUM_TAGS  registered in-flight mask
- free_cnt_o  out  clog2(NUM_TAGS+1)  number of free tags, registered
- full_o  out  1  cur_mask_o all ones
- err_o  out  1  sticky protocol-error flag

## Operation
- State: mask register, free-count register, err flag.
- Let eff_mask = mask & ~res_bit_i when res_valid_i & ~res_wrong_i, else mask.
- Wrong resolution (res_valid_i & res_wrong_i):
  - all grants 0;
  - squash_mask_o = mask & ~res_dep_mask_i;
  - next mask = mask & res_dep_mask_i;
  - clr_bit_o = res_bit_i.
- Correct resolution: clr_bit_o = res_bit_i; squash_mask_o = 0; res_bit_i is cleared from the next mask.
- Allocation pool:
  - pool = free bits of eff_mask if BR_TAG_BYPASS_EN is defined;
  - pool = free bits of mask otherwise.
- Grants are in order:
  - slot k is granted iff alloc_req_i[k], every requesting slot j<k is granted, and an unassigned pool tag remains;
  - granted slots take pool tags lowest-index first, in slot order.
  - A non-requesting slot inside the bundle does not block later slots.
- alloc_mask_o[k] = eff_mask | OR of alloc_bit_o[j] for granted j<k.
- Next mask = eff_mask | OR of all alloc_bit_o. free_cnt tracks popcount(~next mask).
- err_o sets and stays set (until rst) when any of these occurs:
  - res_valid_i with res_bit_i not one-hot;
  - res_valid_i with res_bit_i not set in mask;
  - res_valid_i with res_dep_mask_i & res_bit_i nonzero.
- An erroneous resolution still applies the update rules above.

## Timing
- Reset values: cur_mask_o 0, free_cnt_o NUM_TAGS, full_o 0, err_o 0. All combinational outputs are 0 with no requests or resolution.
- Grants, bits, masks, clr_bit_o and squash_mask_o are valid in the request cycle. cur_mask_o/free_cnt_o reflect them after the next posedge (latency 1).
- Full (mask all ones):
  - without bypass, no grants;
  - with bypass, a simultaneous correct resolution lets slot 0 take the freed tag in the same cycle.
- A tag freed by a wrong resolution is never reallocated in the same cycle; it is available the next cycle.
- rst asserted in any cycle overrides all inputs; the next state is the reset state.

## Configuration
- BR_TAG_BYPASS_EN defined: a tag cleared by a correct resolution is allocatable in the same cycle (pool uses eff_mask).
- BR_TAG_BYPASS_EN undefined: the pool uses the registered mask; freed tags become allocatable one cycle later.
- alloc_mask_o always uses eff_mask in both configurations.

## Test plan
- Reset, then NUM_TAGS=8, DISP_W=2, alloc_req_i=11 for 4 cycles. Required:
  - grants 11 each cycle; bits 0x01/0x02, then 0x04/0x08, and so on;
  - alloc_mask_o[1] of the first bundle = 0x01;
  - after cycle 4, full_o=1 and free_cnt_o=0.
- Full, req=01, correct resolve of bit 0x04:
  - with BR_TAG_BYPASS_EN, gnt=01, bit=0x04, alloc_mask=0xFB;
  - without it, gnt=00, and the next cycle gnt=01 with bit 0x04.
- mask=0x0F, wrong resolve with bit 0x02 and dep 0x01, req=11. Required:
  - gnt=00, squash_mask_o=0x0E, clr_bit_o=0x02;
  - next cur_mask_o=0x01, free_cnt_o=7.
- mask=0xFE, req=11: gnt=01, bit[0]=0x01, slot 1 denied. req=10 with mask=0xFE: gnt=10, bit[1]=0x01.
- Resolve bit 0x20 while mask=0x0F: err_o=1 next cycle and held through further traffic until rst.
- rst mid-stream with mask=0x3C: cur_mask_o=0, free_cnt_o=8, err_o=0 the cycle after.
